wb_write_queue: RTL and testbench

- Write-side companion of the 16x32 register file.
- Accepts completed results (dest, value) from the execute/memory path into an in-order FIFO.
- Drains at most one entry per cycle onto the register file write port (writeBackEn / Dest_wb / Result_WB).
- Keeps a per-register pending-write scoreboard, so decode can stall on RAW hazards against results that have not yet been written back.

---
 rtl/wb_write_queue.sv | 109 ++++++++++
 tb/tb_wb_write_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the 16x32 register file, with a per-register pending-write scoreboard.
// Optional forwarding outputs (fwd1/fwd2) are built when WBQ_FORWARD_EN is defined.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int PCW   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [3:0]              in_dest,
    input  logic [31:0]             in_value,
    output logic                    in_ready,
    input  logic                    wb_hold,
    output logic                    wb_en,
    output logic [3:0]              wb_dest,
    output logic [31:0]             wb_value,
    input  logic [3:0]              src1,
    input  logic [3:0]              src2,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic [$clog2(DEPTH):0]  count
`ifdef WBQ_FORWARD_EN
    ,
    output logic                    fwd1_valid,
    output logic [31:0]             fwd1_data,
    output logic                    fwd2_valid,
    output logic [31:0]             fwd2_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [3:0]     r_dest  [DEPTH];
    logic [31:0]    r_value [DEPTH];
    logic [AW-1:0]  r_rptr;
    logic [AW-1:0]  r_wptr;
    logic [AW:0]    r_count;
    logic [PCW-1:0] r_pend  [16];

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != FULL);
    assign wb_en    = ~w_empty & ~wb_hold & ~rst;
    assign w_push   = in_valid & in_ready & ~rst;
    assign w_pop    = wb_en;
    assign wb_dest  = w_empty ? '0 : r_dest[r_rptr];
    assign wb_value = w_empty ? '0 : r_value[r_rptr];
    assign count    = r_count;
    assign hazard1  = (r_pend[src1] != '0);
    assign hazard2  = (r_pend[src2] != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_wptr]  <= in_dest;
            r_value[r_wptr] <= in_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int unsigned r = 0; r < 16; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // Push and pop of the same register cancel out in the sum.
            for (int unsigned r = 0; r < 16; r++) begin
                r_pend[r] <= r_pend[r]
                             + PCW'(w_push && (in_dest == 4'(r)))
                             - PCW'(w_pop && (r_dest[r_rptr] == 4'(r)));
            end
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [31:0]   w_fwd1;
    logic [31:0]   w_fwd2;
    logic [AW-1:0] w_idx;

    // Scanning oldest to youngest and letting later matches overwrite yields the youngest match.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if (r_dest[w_idx] == src1) w_fwd1 = r_value[w_idx];
                if (r_dest[w_idx] == src2) w_fwd2 = r_value[w_idx];
            end
        end
    end

    assign fwd1_valid = hazard1;
    assign fwd1_data  = w_fwd1;
    assign fwd2_valid = hazard2;
    assign fwd2_data  = w_fwd2;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized scoreboard bench for wb_write_queue; the reference model is a plain queue of pending entries.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_dest;
    logic [31:0] in_value;
    logic        in_ready;
    logic        wb_hold;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard1;
    logic        hazard2;
    logic [$clog2(DEPTH):0] count;
`ifdef WBQ_FORWARD_EN
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
`endif

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .PCW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_dest(in_dest), .in_value(in_value), .in_ready(in_ready),
        .wb_hold(wb_hold), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2), .count(count)
`ifdef WBQ_FORWARD_EN
        , .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
`endif
    );

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t mq[$];   // model of queue contents
    ent_t sb[$];   // expected register-file writes, oldest first
    int   nchk = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_haz(input logic [3:0] s);
        foreach (mq[i]) if (mq[i].d == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [3:0] s);
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].d == s) return mq[i].v;
        return 32'h0;
    endfunction

    // Reference model: advances on each posedge from the inputs held across it.
    always @(posedge clk) begin
        bit pop;
        bit push;
        pop  = (mq.size() != 0) && !wb_hold && !rst;
        push = !rst && in_valid && (mq.size() < DEPTH);
        if (rst) begin
            mq.delete();
            sb.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{in_dest, in_value});
                sb.push_back('{in_dest, in_value});
            end
        end
    end

    // Status checks against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("wb_en", 32'(wb_en), 32'((mq.size() != 0) && !wb_hold && !rst));
            chk("hazard1", 32'(hazard1), 32'(m_haz(src1)));
            chk("hazard2", 32'(hazard2), 32'(m_haz(src2)));
            if (mq.size() == 0) begin
                chk("wb_dest_empty", 32'(wb_dest), 32'h0);
                chk("wb_value_empty", wb_value, 32'h0);
            end
`ifdef WBQ_FORWARD_EN
            chk("fwd1_valid", 32'(fwd1_valid), 32'(m_haz(src1)));
            chk("fwd1_data", fwd1_data, m_fwd(src1));
            chk("fwd2_valid", 32'(fwd2_valid), 32'(m_haz(src2)));
            chk("fwd2_data", fwd2_data, m_fwd(src2));
`endif
        end
    end

    // Write-back monitor: each write must match the next expected one.
    always @(negedge clk) begin
        ent_t e;
        if (chk_en && wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL wb_unexpected: got write dest %h value %h expected none", wb_dest, wb_value);
            end else begin
                e = sb.pop_front();
                chk("wb_dest", 32'(wb_dest), 32'(e.d));
                chk("wb_value", wb_value, e.v);
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] d, input logic [31:0] val, input bit h,
                        input logic [3:0] s1, input logic [3:0] s2, input bit r = 1'b0);
        in_valid = v;
        in_dest  = d;
        in_value = val;
        wb_hold  = h;
        src1     = s1;
        src2     = s2;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_value = '0;
        wb_hold = 1'b0; src1 = '0; src2 = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1);

        // Single push, one-cycle latency to write-back.
        step(1, 3, 32'hDEADBEEF, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);

        // Fill under hold, overflow push dropped, then drain.
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 32'(i * 16), 1, 4'(i), 1);
        step(1, 5, 32'h50, 1, 5, 4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4, 2);

        // Two writes to one register.
        step(1, 7, 32'h1, 1, 0, 7);
        step(1, 7, 32'h2, 1, 0, 7);
        step(0, 0, 0, 1, 0, 7);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 7);

        // Streaming across pointer wrap.
        for (int i = 0; i < 3 * DEPTH; i++) step(1, 4'(i % 16), 32'(i), 0, 4'(i % 16), 4'((i + 15) % 16));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset mid-operation with a simultaneous push.
        for (int i = 0; i < 3; i++) step(1, 4'(10 + i), 32'(100 + i), 1, 10, 14);
        step(1, 14, 32'h55, 1, 10, 14, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 10, 14);

        // Youngest-entry forwarding.
        step(1, 9, 32'hA, 1, 9, 0);
        step(1, 9, 32'hB, 1, 9, 0);
        step(0, 0, 0, 1, 9, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 9, 0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 5)), $urandom,
                 bit'($urandom_range(0, 9) < 3), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
                 bit'($urandom_range(0, 99) == 0));
        end

        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
